countdown_timer_bcd: RTL
========================

Name: countdown_timer_bcd

Overview:
Parametrised countdown timer for the RTC timer path. It loads an h:m:s preset in binary and decrements it once per 1 Hz tick. It raises a latched alarm at 00:00:00 and presents the remaining time as registered two-digit BCD per field for the display/VGA path. It replaces the combinational "max minus count" correction followed by per-field BCD conversion with a stateful counter and a shared multi-cycle converter.

Parameters:
W, 8, width of binary time fields (in and internal)
SEC_MAX, 59, seconds reload value on borrow; must be <= 99
MIN_MAX, 59, minutes reload value on borrow; must be <= 99
HOUR_MAX, 23, hours clamp limit; must be <= 99

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
tick  in  1  one-cycle 1 Hz enable, synchronous to clk
load  in  1  load preset from h_in/m_in/s_in
start  in  1  begin/resume counting
stop  in  1  pause counting
alarm_ack  in  1  clear alarm, return to IDLE
h_in, m_in, s_in  in  W each  binary preset
ht, mt, st  out  8 each  remaining time, BCD {tens,units}
bcd_valid  out  1  BCD outputs match current count
running  out  1  high in RUN
alarm  out  1  latched expiry flag
done  out  1  one-cycle pulse on expiry

Behaviour:
- One clock domain. Reset is synchronous and active-low on `reset`.
- Reset values:
  - state = IDLE; h/m/s counters = 0.
  - ht = mt = st = 8'h00; bcd_valid = 1.
  - running = 0; alarm = 0; done = 0.
- FSM states: IDLE, RUN, PAUSE, EXPIRED.
- IDLE:
  - load latches the preset. Each field is clamped: s > SEC_MAX -> SEC_MAX, m > MIN_MAX -> MIN_MAX, h > HOUR_MAX -> HOUR_MAX.
  - start with a nonzero count -> RUN.
  - start with count == 0 is ignored.
- RUN (running = 1):
  - On tick, decrement with borrow:
    - s > 0: s - 1.
    - else m > 0: s = SEC_MAX, m - 1.
    - else h > 0: s = SEC_MAX, m = MIN_MAX, h - 1.
  - If the post-decrement value is 00:00:00: go to EXPIRED, set alarm = 1, pulse done for exactly one cycle.
  - stop -> PAUSE.
  - load is ignored in RUN.
- PAUSE:
  - Count frozen; ticks ignored.
  - load is accepted (clamped).
  - start with a nonzero count -> RUN.
- EXPIRED:
  - Count holds 0; alarm stays 1; ticks ignored.
  - alarm_ack -> IDLE with alarm = 0.
  - load is accepted and also clears alarm -> IDLE.
- Same-cycle priority:
  - stop over start.
  - load over start: the preset is taken and start is ignored that cycle.
  - alarm_ack and load together: both take effect.
  - tick with stop in RUN: the decrement is applied, then the FSM enters PAUSE.
  - tick on the final second together with stop: EXPIRED wins.
- BCD converter:
  - Sequential shift-add-3 (double dabble), one instance time-shared or three in parallel. Either way W shift cycles are required.
  - Triggered on any count change: load, decrement, or reset release.
  - On trigger, bcd_valid drops to 0 on the next cycle.
  - After W + 1 cycles, ht/mt/st update together and bcd_valid returns to 1.
  - Outputs hold their previous value while converting; never show partial results.
  - A retrigger during conversion restarts it with a fresh snapshot of the count.
- Field values never exceed 99, so the upper BCD bits beyond two digits are unused. No overflow logic is required.
- Reset asserted mid-conversion or mid-count aborts everything to the reset values on the next edge.

Test Plan:
- Reset, then load 0:1:5 and start; apply 5 ticks -> st sequence 04,03,02,01,00 with mt=01. The next tick gives mt=00, st=59 (SEC_MAX reload). bcd_valid returns within W+1 = 9 cycles of each tick.
- Load 0:0:2, start, 2 ticks -> second tick: alarm=1, done high exactly 1 cycle, ht/mt/st = 00. Further ticks leave the outputs unchanged. alarm_ack -> alarm=0, FSM back in IDLE.
- Load h=30, m=75, s=99 -> clamped count reads ht=23, mt=59, st=59. Start, then 1 tick -> 23:59:58.
- In RUN, assert stop and tick in the same cycle at 0:0:10 -> count 0:0:09, running=0. 3 further ticks -> still 0:0:09. start -> running=1, next tick -> 0:0:08.
- start with count 00:00:00 -> stays IDLE, running=0, no done pulse. start and stop in the same cycle from PAUSE -> remains PAUSE.
- Drive reset low during a conversion following a load of 12:34:56 -> next edge gives ht=mt=st=00, bcd_valid=1, alarm=0. Load issued during RUN is ignored (count unchanged).

Source files
------------

// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd
//   Loads an h:m:s preset in binary, clamps each field, and counts down once
//   per 1 Hz tick. It raises a latched alarm and a one-cycle done pulse when
//   the count reaches 00:00:00. The remaining time is presented as registered
//   two-digit BCD per field. Three parallel shift-add-3 converters take W shift
//   cycles plus one publish cycle. Results appear only when complete.
// Ports:
//   clk, reset (sync, active-low)   clock / reset
//   tick                            one-cycle 1 Hz enable
//   load, start, stop, alarm_ack    control strobes
//   h_in, m_in, s_in [W-1:0]        binary preset
//   ht, mt, st [7:0]                BCD remaining time {tens,units}
//   bcd_valid                       BCD outputs match the current count
//   running / alarm / done          RUN state / latched expiry / expiry pulse
module countdown_timer_bcd #(
  parameter int W        = 8,
  parameter int SEC_MAX  = 59,
  parameter int MIN_MAX  = 59,
  parameter int HOUR_MAX = 23
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         load,
  input  logic         start,
  input  logic         stop,
  input  logic         alarm_ack,
  input  logic [W-1:0] h_in,
  input  logic [W-1:0] m_in,
  input  logic [W-1:0] s_in,
  output logic [7:0]   ht,
  output logic [7:0]   mt,
  output logic [7:0]   st,
  output logic         bcd_valid,
  output logic         running,
  output logic         alarm,
  output logic         done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, EXPIRED = 2'd3} state_t;

  localparam logic [W-1:0] SEC_LIM  = W'(SEC_MAX);
  localparam logic [W-1:0] MIN_LIM  = W'(MIN_MAX);
  localparam logic [W-1:0] HOUR_LIM = W'(HOUR_MAX);
  localparam logic [W-1:0] ZERO     = {W{1'b0}};
  localparam logic [W-1:0] ONE      = W'(1);
  localparam int           CW       = $clog2(W + 2);
  localparam logic [CW-1:0] STEP_LAST = CW'(W);

  // Saturate a preset field at its limit.
  function automatic logic [W-1:0] clamp(input logic [W-1:0] v, input logic [W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // One double-dabble step: add 3 to any digit >= 5, then shift in the next bit.
  function automatic logic [7:0] dd_step(input logic [7:0] bcd, input logic bit_in);
    logic [7:0] adj;
    adj = bcd;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    else                  adj[3:0] = adj[3:0];
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    else                  adj[7:4] = adj[7:4];
    return {adj[6:0], bit_in};
  endfunction

  state_t         state_r, state_nxt;
  logic [W-1:0]   h_r, m_r, s_r, h_nxt, m_nxt, s_nxt;
  logic [W-1:0]   h_dec_s, m_dec_s, s_dec_s;
  logic           count_zero_s, dec_zero_s, change_s;
  logic           alarm_r, alarm_nxt, done_r, done_nxt, running_r;
  logic           init_r;
  logic [W-1:0]   h_sh_r, m_sh_r, s_sh_r;
  logic [7:0]     h_bcd_r, m_bcd_r, s_bcd_r;
  logic [7:0]     ht_r, mt_r, st_r;
  logic           valid_r, busy_r;
  logic [CW-1:0]  step_r;

  assign count_zero_s = (h_r == ZERO) && (m_r == ZERO) && (s_r == ZERO);
  assign dec_zero_s   = (h_dec_s == ZERO) && (m_dec_s == ZERO) && (s_dec_s == ZERO);

  // Decrement-with-borrow of the current count.
  always_comb begin
    h_dec_s = h_r;
    m_dec_s = m_r;
    s_dec_s = s_r;
    if (s_r != ZERO) begin
      s_dec_s = s_r - ONE;
    end else if (m_r != ZERO) begin
      s_dec_s = SEC_LIM;
      m_dec_s = m_r - ONE;
    end else if (h_r != ZERO) begin
      s_dec_s = SEC_LIM;
      m_dec_s = MIN_LIM;
      h_dec_s = h_r - ONE;
    end else begin
      s_dec_s = s_r;
    end
  end

  // Next-state, next-count and flag logic; change_s marks any count update.
  always_comb begin
    state_nxt = state_r;
    h_nxt     = h_r;
    m_nxt     = m_r;
    s_nxt     = s_r;
    alarm_nxt = alarm_r;
    done_nxt  = 1'b0;
    change_s  = 1'b0;
    case (state_r)
      IDLE, PAUSE: begin
        // load outranks start; stop outranks start
        if (load) begin
          h_nxt    = clamp(h_in, HOUR_LIM);
          m_nxt    = clamp(m_in, MIN_LIM);
          s_nxt    = clamp(s_in, SEC_LIM);
          change_s = 1'b1;
        end else if (start && !stop && !count_zero_s) begin
          state_nxt = RUN;
        end else begin
          state_nxt = state_r;
        end
      end
      RUN: begin
        // a tick is applied before stop; reaching zero outranks stop
        if (tick) begin
          h_nxt    = h_dec_s;
          m_nxt    = m_dec_s;
          s_nxt    = s_dec_s;
          change_s = 1'b1;
          if (dec_zero_s) begin
            state_nxt = EXPIRED;
            alarm_nxt = 1'b1;
            done_nxt  = 1'b1;
          end else if (stop) begin
            state_nxt = PAUSE;
          end else begin
            state_nxt = RUN;
          end
        end else if (stop) begin
          state_nxt = PAUSE;
        end else begin
          state_nxt = RUN;
        end
      end
      EXPIRED: begin
        if (load) begin
          h_nxt     = clamp(h_in, HOUR_LIM);
          m_nxt     = clamp(m_in, MIN_LIM);
          s_nxt     = clamp(s_in, SEC_LIM);
          change_s  = 1'b1;
          alarm_nxt = 1'b0;
          state_nxt = IDLE;
        end else if (alarm_ack) begin
          alarm_nxt = 1'b0;
          state_nxt = IDLE;
        end else begin
          state_nxt = EXPIRED;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, count and status flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      h_r       <= ZERO;
      m_r       <= ZERO;
      s_r       <= ZERO;
      alarm_r   <= 1'b0;
      done_r    <= 1'b0;
      running_r <= 1'b0;
      init_r    <= 1'b1;
    end else begin
      state_r   <= state_nxt;
      h_r       <= h_nxt;
      m_r       <= m_nxt;
      s_r       <= s_nxt;
      alarm_r   <= alarm_nxt;
      done_r    <= done_nxt;
      running_r <= (state_nxt == RUN);
      init_r    <= 1'b0;
    end
  end

  // BCD converter: snapshot the new count, W shift steps, then publish.
  // init_r makes the first cycle after reset release count as a trigger.
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_sh_r  <= ZERO;
      m_sh_r  <= ZERO;
      s_sh_r  <= ZERO;
      h_bcd_r <= 8'h00;
      m_bcd_r <= 8'h00;
      s_bcd_r <= 8'h00;
      ht_r    <= 8'h00;
      mt_r    <= 8'h00;
      st_r    <= 8'h00;
      valid_r <= 1'b1;
      busy_r  <= 1'b0;
      step_r  <= {CW{1'b0}};
    end else if (change_s || init_r) begin
      h_sh_r  <= h_nxt;
      m_sh_r  <= m_nxt;
      s_sh_r  <= s_nxt;
      h_bcd_r <= 8'h00;
      m_bcd_r <= 8'h00;
      s_bcd_r <= 8'h00;
      valid_r <= 1'b0;
      busy_r  <= 1'b1;
      step_r  <= {CW{1'b0}};
    end else if (busy_r) begin
      if (step_r == STEP_LAST) begin
        ht_r    <= h_bcd_r;
        mt_r    <= m_bcd_r;
        st_r    <= s_bcd_r;
        valid_r <= 1'b1;
        busy_r  <= 1'b0;
      end else begin
        h_bcd_r <= dd_step(h_bcd_r, h_sh_r[W-1]);
        m_bcd_r <= dd_step(m_bcd_r, m_sh_r[W-1]);
        s_bcd_r <= dd_step(s_bcd_r, s_sh_r[W-1]);
        h_sh_r  <= {h_sh_r[W-2:0], 1'b0};
        m_sh_r  <= {m_sh_r[W-2:0], 1'b0};
        s_sh_r  <= {s_sh_r[W-2:0], 1'b0};
        step_r  <= step_r + CW'(1);
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

  assign ht        = ht_r;
  assign mt        = mt_r;
  assign st        = st_r;
  assign bcd_valid = valid_r;
  assign running   = running_r;
  assign alarm     = alarm_r;
  assign done      = done_r;

endmodule
